tx_iq_intf: RTL and testbench

Transmit-side I/Q buffer between the wifi transmitter (or the s_axis DMA loopback source) and the DAC front-end.
It accepts bursty I/Q into a 64-deep FIFO and prefills before starting, then plays samples out at one per CLK_PER_SAMPLE clocks.
It appends zero-valued tail samples to flush the DAC filter chain, and reports underrun and overflow.

---
 rtl/tx_intf_pkg.sv | 26 ++
 rtl/tx_iq_fifo.sv | 67 ++++++
 rtl/tx_iq_intf.sv | 215 +++++++++++++++++++++
 tb/tb_tx_iq_intf.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_intf_pkg.sv
`default_nettype none
// ============================================================================
// tx_intf_pkg : shared FSM encoding, I/Q word lane layout, ready headroom
// Rev 1.0
// ============================================================================
package tx_intf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2,
        ST_TAIL    = 2'd3
    } tx_state_t;

    // Word layout matches the DMA format: I in the low lane, Q in the high lane.
    localparam int I_LANE = 0;
    localparam int Q_LANE = 1;

    localparam int READY_HEADROOM = 4;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_iq_fifo.sv
`default_nettype none
// ============================================================================
// tx_iq_fifo : single-clock FIFO; read data is registered and reads 0 on
//              any cycle that does not follow a read.    Rev 1.0
// ============================================================================
module tx_iq_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   data_count
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (data_count == FULL_COUNT);
    assign empty = (data_count == '0);

    // A write while full is dropped even if a read frees a slot this cycle.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            rd_data    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_data <= do_rd ? mem[rd_ptr] : '0;
            case ({do_wr, do_rd})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_iq_intf.sv
`default_nettype none
// ============================================================================
// tx_iq_intf : transmit I/Q buffer with prefill, paced DAC playout and a
//              zero tail; flags underrun and overflow.    Rev 1.0
// ============================================================================
module tx_iq_intf
    import tx_intf_pkg::*;
#(
    parameter int IQ_DATA_WIDTH          = 16,
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_DEPTH_LOG2        = 6,
    parameter int CLK_PER_SAMPLE         = 5,
    parameter int PREFILL_LEVEL          = 16,
    parameter int TAIL_ZEROS             = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              src_sel,
    input  logic [IQ_DATA_WIDTH-1:0]          tx_i,
    input  logic [IQ_DATA_WIDTH-1:0]          tx_q,
    input  logic                              tx_iq_valid,
    output logic                              tx_iq_ready,
    input  logic                              tx_end,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_from_s_axis,
    input  logic                              emptyn_from_s_axis,
    output logic                              ask_data_from_s_axis,
    input  logic                              fifo_in_en,
    input  logic                              fifo_out_en,
    output logic [IQ_DATA_WIDTH-1:0]          dac_i,
    output logic [IQ_DATA_WIDTH-1:0]          dac_q,
    output logic                              dac_iq_valid,
    output logic                              tx_active,
    output logic                              underrun_sticky,
    output logic                              overflow_sticky,
    input  logic                              sticky_clr,
    output logic [FIFO_DEPTH_LOG2:0]          fifo_data_count
);

    localparam int WORD_W  = 2 * IQ_DATA_WIDTH;
    localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int I_LSB   = lane_lsb(I_LANE, IQ_DATA_WIDTH);
    localparam int Q_LSB   = lane_lsb(Q_LANE, IQ_DATA_WIDTH);
    localparam int PHASE_W = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam int TAIL_W  = (TAIL_ZEROS > 1) ? $clog2(TAIL_ZEROS) : 1;
    // The strobe that finds the FIFO empty already emits the first tail zero.
    localparam int TAIL_LOAD = (TAIL_ZEROS > 1) ? TAIL_ZEROS - 1 : 0;

    localparam logic [CNT_W-1:0]   READY_LIMIT = CNT_W'((2 ** FIFO_DEPTH_LOG2) - READY_HEADROOM);
    localparam logic [CNT_W-1:0]   PREFILL_CNT = CNT_W'(PREFILL_LEVEL);
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(CLK_PER_SAMPLE - 1);

    tx_state_t           state;
    logic [PHASE_W-1:0]  phase;
    logic [TAIL_W-1:0]   tail_cnt;
    logic                end_seen;
    logic                strobe;
    logic                step;
    logic                wifi_wr;
    logic                wr_req;
    logic                wr_ok;
    logic                rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   wifi_word;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   rd_word;

    // ------------------------------------------------------------------
    // Sample pacing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= '0;
        end else if (phase == PHASE_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign strobe = (phase == '0);
    assign step   = strobe & fifo_out_en;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_comb begin
        wifi_word                          = '0;
        wifi_word[I_LSB +: IQ_DATA_WIDTH]  = tx_i;
        wifi_word[Q_LSB +: IQ_DATA_WIDTH]  = tx_q;
    end

    assign wifi_wr              = tx_iq_valid & fifo_in_en & ~src_sel;
    assign ask_data_from_s_axis = src_sel & emptyn_from_s_axis & ~fifo_full & fifo_in_en;
    assign wr_req               = wifi_wr | ask_data_from_s_axis;
    assign wr_ok                = wr_req & ~fifo_full;
    assign wr_word              = src_sel ? data_from_s_axis[WORD_W-1:0] : wifi_word;
    assign tx_iq_ready          = ~src_sel & fifo_in_en & (fifo_data_count < READY_LIMIT);

    generate
        if (C_S00_AXIS_TDATA_WIDTH > WORD_W) begin : g_axis_unused
            logic unused_axis_bits;
            assign unused_axis_bits = ^data_from_s_axis[C_S00_AXIS_TDATA_WIDTH-1:WORD_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read side and FIFO
    // ------------------------------------------------------------------
    assign rd = step & (state == ST_STREAM) & ~fifo_empty;

    tx_iq_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (wr_req),
        .wr_data    (wr_word),
        .rd_en      (rd),
        .rd_data    (rd_word),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .data_count (fifo_data_count)
    );

    // FIFO read data is already zero when no read happened, so it is the DAC word.
    assign dac_i = rd_word[I_LSB +: IQ_DATA_WIDTH];
    assign dac_q = rd_word[Q_LSB +: IQ_DATA_WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dac_iq_valid <= 1'b0;
        end else begin
            dac_iq_valid <= step & (state != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            tx_active <= 1'b0;
            end_seen  <= 1'b0;
            tail_cnt  <= '0;
        end else begin
            if (tx_end && (state != ST_IDLE || wr_ok)) begin
                end_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (wr_ok) begin
                        state     <= ST_PREFILL;
                        tx_active <= 1'b1;
                    end
                end
                ST_PREFILL: begin
                    if (fifo_data_count >= PREFILL_CNT || end_seen) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (step && fifo_empty && end_seen) begin
                        if (TAIL_ZEROS <= 1) begin
                            state     <= ST_IDLE;
                            tx_active <= 1'b0;
                            end_seen  <= 1'b0;
                        end else begin
                            state    <= ST_TAIL;
                            tail_cnt <= TAIL_W'(TAIL_LOAD);
                        end
                    end
                end
                ST_TAIL: begin
                    if (step) begin
                        tail_cnt <= tail_cnt - 1'b1;
                        if (tail_cnt <= TAIL_W'(1)) begin
                            state     <= ST_IDLE;
                            tx_active <= 1'b0;
                            end_seen  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky status; clear wins over a same-cycle set
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun_sticky <= 1'b0;
            overflow_sticky <= 1'b0;
        end else if (sticky_clr) begin
            underrun_sticky <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            if (step && state == ST_STREAM && fifo_empty && !end_seen) begin
                underrun_sticky <= 1'b1;
            end
            if (wifi_wr && fifo_full) begin
                overflow_sticky <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_iq_intf.sv
`default_nettype none
// ============================================================================
// tb_tx_iq_intf : self-checking bench for tx_iq_intf    Rev 1.0
// ============================================================================
module tb_tx_iq_intf;

    logic        clk = 1'b0;
    logic        rstn;
    logic        src_sel;
    logic [15:0] tx_i;
    logic [15:0] tx_q;
    logic        tx_iq_valid;
    logic        tx_iq_ready;
    logic        tx_end;
    logic [63:0] data_from_s_axis;
    logic        emptyn_from_s_axis;
    logic        ask_data_from_s_axis;
    logic        fifo_in_en;
    logic        fifo_out_en;
    logic [15:0] dac_i;
    logic [15:0] dac_q;
    logic        dac_iq_valid;
    logic        tx_active;
    logic        underrun_sticky;
    logic        overflow_sticky;
    logic        sticky_clr;
    logic [6:0]  fifo_data_count;

    tx_iq_intf dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .src_sel              (src_sel),
        .tx_i                 (tx_i),
        .tx_q                 (tx_q),
        .tx_iq_valid          (tx_iq_valid),
        .tx_iq_ready          (tx_iq_ready),
        .tx_end               (tx_end),
        .data_from_s_axis     (data_from_s_axis),
        .emptyn_from_s_axis   (emptyn_from_s_axis),
        .ask_data_from_s_axis (ask_data_from_s_axis),
        .fifo_in_en           (fifo_in_en),
        .fifo_out_en          (fifo_out_en),
        .dac_i                (dac_i),
        .dac_q                (dac_q),
        .dac_iq_valid         (dac_iq_valid),
        .tx_active            (tx_active),
        .underrun_sticky      (underrun_sticky),
        .overflow_sticky      (overflow_sticky),
        .sticky_clr           (sticky_clr),
        .fifo_data_count      (fifo_data_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit emptyn;
        bit in_en;
        bit exp_ask;
    } axis_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          started = 1'b0;
    int          lead_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lead(input int lo, input int hi);
        checks++;
        if (lead_seen < lo || lead_seen > hi) begin
            errors++;
            $display("FAIL lead_zeros actual=%0d required=%0d..%0d", lead_seen, lo, hi);
        end
    endtask

    // Scoreboard: zero samples before the first data word of a packet are prefill strobes.
    always @(negedge clk) begin
        if (mon_en && rstn && dac_iq_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dac_extra actual=0x%0h required=no_sample", {dac_q, dac_i});
            end else if (!started && {dac_q, dac_i} == 32'h0 && exp_q[0] != 32'h0) begin
                lead_seen++;
            end else begin
                started = 1'b1;
                check("dac_sample", {dac_q, dac_i}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt();
        started   = 1'b0;
        lead_seen = 0;
    endtask

    task automatic push_zeros(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(32'h0);
    endtask

    task automatic write_wifi(input int n, input logic [15:0] qbase, input bit end_last, input bit push);
        for (int k = 1; k <= n; k++) begin
            tx_i        = 16'(k);
            tx_q        = qbase + 16'(k);
            tx_iq_valid = 1'b1;
            tx_end      = end_last && (k == n);
            if (push) exp_q.push_back({tx_q, tx_i});
            tick();
        end
        tx_iq_valid = 1'b0;
        tx_end      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit need_idle);
        int n = 0;
        while ((exp_q.size() != 0 || (need_idle && tx_active)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    task automatic wait_valid(input int budget, input bit need_nonzero);
        int n = 0;
        while (!(dac_iq_valid && (!need_nonzero || dac_i != 16'h0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout actual=none required=dac_iq_valid");
        end
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axis_vec_t vecs[12];
        int        valid_cnt;

        vecs[0]  = '{1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1};

        rstn               = 1'b0;
        src_sel            = 1'b0;
        tx_i               = '0;
        tx_q               = '0;
        tx_iq_valid        = 1'b0;
        tx_end             = 1'b0;
        data_from_s_axis   = '0;
        emptyn_from_s_axis = 1'b0;
        fifo_in_en         = 1'b1;
        fifo_out_en        = 1'b1;
        sticky_clr         = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_dac_valid", 32'(dac_iq_valid), 32'h0);
        check("rst_dac_iq", {dac_q, dac_i}, 32'h0);
        check("rst_tx_active", 32'(tx_active), 32'h0);
        check("rst_count", 32'(fifo_data_count), 32'h0);
        check("rst_stickies", {30'h0, underrun_sticky, overflow_sticky}, 32'h0);
        check("rst_ask", 32'(ask_data_from_s_axis), 32'h0);
        check("rst_ready", 32'(tx_iq_ready), 32'h1);
        tick();
        rstn = 1'b1;
        tick();

        // Normal packet: 20 samples, tx_end with the last
        mon_en = 1'b1;
        start_pkt();
        write_wifi(20, 16'h8000, 1'b1, 1'b1);
        push_zeros(8);
        wait_done(400, 1'b1);
        repeat (12) @(negedge clk);
        check("norm_queue_left", 32'(exp_q.size()), 32'h0);
        check_lead(3, 4);
        check("norm_underrun", 32'(underrun_sticky), 32'h0);
        check("norm_tx_active", 32'(tx_active), 32'h0);
        check("norm_count", 32'(fifo_data_count), 32'h0);

        // Short packet: 3 samples, never reaches prefill level
        tick();
        start_pkt();
        write_wifi(3, 16'h2000, 1'b1, 1'b1);
        push_zeros(8);
        wait_done(300, 1'b1);
        repeat (12) @(negedge clk);
        check("short_queue_left", 32'(exp_q.size()), 32'h0);
        check_lead(0, 1);
        check("short_underrun", 32'(underrun_sticky), 32'h0);
        check("short_tx_active", 32'(tx_active), 32'h0);

        // Underrun: 16 samples and no tx_end
        tick();
        start_pkt();
        write_wifi(16, 16'h1000, 1'b0, 1'b1);
        push_zeros(1);
        wait_done(400, 1'b0);
        mon_en = 1'b0;
        check_lead(3, 4);
        check("ur_sticky_set", 32'(underrun_sticky), 32'h1);
        check("ur_still_active", 32'(tx_active), 32'h1);
        wait_valid(20, 1'b0);
        tick();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        @(negedge clk);
        check("ur_sticky_clr", 32'(underrun_sticky), 32'h0);
        tick();
        sticky_clr = 1'b1;
        repeat (10) tick();
        sticky_clr = 1'b0;
        @(negedge clk);
        check("ur_clr_priority", 32'(underrun_sticky), 32'h0);
        repeat (6) tick();
        check("ur_sticky_reset", 32'(underrun_sticky), 32'h1);
        pulse_reset();

        // Reset mid-packet while the DAC carries a data word
        write_wifi(20, 16'h3000, 1'b0, 1'b0);
        wait_valid(300, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(dac_iq_valid), 32'h0);
        check("mid_rst_dac", {dac_q, dac_i}, 32'h0);
        check("mid_rst_active", 32'(tx_active), 32'h0);
        check("mid_rst_count", 32'(fifo_data_count), 32'h0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(tx_iq_ready), 32'h1);
        check("post_rst_count", 32'(fifo_data_count), 32'h0);
        valid_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dac_iq_valid) valid_cnt++;
        end
        check("post_rst_idle_valid", 32'(valid_cnt), 32'h0);

        // Overflow: output disabled, 70 writes into a 64-deep FIFO
        tick();
        fifo_out_en = 1'b0;
        mon_en      = 1'b1;
        start_pkt();
        for (int k = 1; k <= 70; k++) begin
            tx_i        = 16'(k);
            tx_q        = 16'h4000 + 16'(k);
            tx_iq_valid = 1'b1;
            if (k <= 64) exp_q.push_back({tx_q, tx_i});
            tick();
            @(negedge clk);
            check("ovf_count", 32'(fifo_data_count), (k < 64) ? 32'(k) : 32'd64);
            check("ovf_ready", 32'(tx_iq_ready), (k < 60) ? 32'h1 : 32'h0);
            check("ovf_sticky", 32'(overflow_sticky), (k > 64) ? 32'h1 : 32'h0);
        end
        tx_iq_valid = 1'b0;
        tick();
        fifo_out_en = 1'b1;
        tx_end      = 1'b1;
        tick();
        tx_end = 1'b0;
        push_zeros(8);
        wait_done(800, 1'b1);
        repeat (12) @(negedge clk);
        check("ovf_queue_left", 32'(exp_q.size()), 32'h0);
        check_lead(0, 0);
        check("ovf_underrun", 32'(underrun_sticky), 32'h0);
        check("ovf_sticky_held", 32'(overflow_sticky), 32'h1);
        tick();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        @(negedge clk);
        check("ovf_sticky_clr", 32'(overflow_sticky), 32'h0);

        // s_axis source, table-driven handshake
        tick();
        src_sel          = 1'b1;
        data_from_s_axis = 64'h0000_0000_AAAA_5555;
        tx_iq_valid      = 1'b1;
        tx_i             = 16'hDEAD;
        tx_q             = 16'hBEEF;
        start_pkt();
        for (int v = 0; v < 12; v++) begin
            emptyn_from_s_axis = vecs[v].emptyn;
            fifo_in_en         = vecs[v].in_en;
            if (vecs[v].exp_ask) exp_q.push_back(32'hAAAA_5555);
            @(negedge clk);
            check("axis_ask", 32'(ask_data_from_s_axis), 32'(vecs[v].exp_ask));
            check("axis_ready", 32'(tx_iq_ready), 32'h0);
            tick();
        end
        emptyn_from_s_axis = 1'b0;
        fifo_in_en         = 1'b1;
        tx_iq_valid        = 1'b0;
        tx_end             = 1'b1;
        tick();
        tx_end = 1'b0;
        push_zeros(8);
        wait_done(400, 1'b1);
        repeat (12) @(negedge clk);
        check("axis_queue_left", 32'(exp_q.size()), 32'h0);
        check_lead(0, 4);
        check("axis_overflow", 32'(overflow_sticky), 32'h0);
        mon_en  = 1'b0;
        src_sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
